// File: rtl/traffic_lamp_monitor_if.sv
// Signal bundle between the four-way traffic controller (master) and traffic_lamp_monitor (slave).
interface traffic_lamp_monitor_if;
  logic [1:0] n_lights;
  logic [1:0] s_lights;
  logic [1:0] e_lights;
  logic [1:0] w_lights;
  logic       clr_fault;
  logic [2:0] n_lamp;
  logic [2:0] s_lamp;
  logic [2:0] e_lamp;
  logic [2:0] w_lamp;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output n_lights, s_lights, e_lights, w_lights, clr_fault,
    input  n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code
  );

  modport slave (
    input  n_lights, s_lights, e_lights, w_lights, clr_fault,
    output n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code
  );
endinterface

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor behind the four-way traffic controller: registers light codes, drives one-hot lamps and
// latches conflict/illegal/watchdog faults into flashing red. Watchdog exists only with TRAFFIC_LAMP_WATCHDOG_EN.
module traffic_lamp_monitor #(
  parameter int INIT_CYCLES     = 4,
  parameter int CONFLICT_CYCLES = 2,
  parameter int WATCHDOG_CYCLES = 32,
  parameter int BLINK_DIV       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_lamp_monitor_if.slave bus
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;
  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_CONFLICT = 2'b01,
    FC_ILLEGAL  = 2'b10,
    FC_WATCHDOG = 2'b11
  } fault_code_t;

  localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
  localparam int CONF_W  = $clog2(CONFLICT_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [INIT_W-1:0]  INIT_MAX   = INIT_W'(INIT_CYCLES);
  localparam logic [CONF_W-1:0]  CONF_MAX   = CONF_W'(CONFLICT_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  function automatic logic [2:0] decode_lamp(input logic [1:0] code);
    case (code)
      2'b00:   return LAMP_RED;
      2'b01:   return LAMP_YELLOW;
      2'b10:   return LAMP_GREEN;
      default: return LAMP_OFF;
    endcase
  endfunction

  // Approach index: 0 = north, 1 = south, 2 = east, 3 = west.
  logic [3:0][1:0]    w_codes;
  logic [3:0][1:0]    r_in_q;
  logic [3:0]         w_nonred;
  logic               w_illegal;
  logic               w_multi;
  logic               w_conf_hit;
  logic               w_wd_hit;
  logic               w_fault_now;
  logic [CONF_W-1:0]  r_conf_cnt;
  logic [CONF_W-1:0]  w_conf_inc;
  state_t             r_state;
  state_t             w_state_nxt;
  fault_code_t        r_code;
  fault_code_t        w_code_nxt;
  logic [INIT_W-1:0]  r_init_cnt;
  logic [INIT_W-1:0]  w_init_nxt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [BLINK_W-1:0] w_blink_cnt_nxt;
  logic               r_blink;
  logic               w_blink_nxt;
  logic [3:0][2:0]    r_lamp;
  logic [3:0][2:0]    w_lamp_nxt;

  assign w_codes = {bus.w_lights, bus.e_lights, bus.s_lights, bus.n_lights};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_q <= '0;
    else     r_in_q <= w_codes;
  end

  always_comb begin
    w_illegal = 1'b0;
    w_nonred  = '0;
    for (int i = 0; i < 4; i++) begin
      w_nonred[i] = (r_in_q[i] != 2'b00);
      w_illegal   = w_illegal | (r_in_q[i] == 2'b11);
    end
    // Two or more bits set: clearing the lowest set bit leaves something behind.
    w_multi = ((w_nonred & (w_nonred - 4'd1)) != 4'd0);
    if (!w_multi)                    w_conf_inc = '0;
    else if (r_conf_cnt == CONF_MAX) w_conf_inc = r_conf_cnt;
    else                             w_conf_inc = r_conf_cnt + CONF_W'(1);
    w_conf_hit = w_multi && (w_conf_inc == CONF_MAX);
  end

`ifdef TRAFFIC_LAMP_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);

  logic [3:0][WD_W-1:0] r_wd_cnt;
  logic [3:0][WD_W-1:0] w_wd_inc;

  always_comb begin
    w_wd_hit = 1'b0;
    w_wd_inc = '0;
    for (int i = 0; i < 4; i++) begin
      if (!w_nonred[i])               w_wd_inc[i] = '0;
      else if (r_wd_cnt[i] == WD_MAX) w_wd_inc[i] = r_wd_cnt[i];
      else                            w_wd_inc[i] = r_wd_cnt[i] + WD_W'(1);
      w_wd_hit = w_wd_hit | (w_wd_inc[i] == WD_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_wd_cnt <= '0;
    else if (r_state == ST_RUN && !w_fault_now) r_wd_cnt <= w_wd_inc;
    else                                       r_wd_cnt <= '0;
  end
`else
  logic w_unused_wd;
  assign w_wd_hit    = 1'b0;
  assign w_unused_wd = (WATCHDOG_CYCLES != 0);
`endif

  assign w_fault_now = (r_state == ST_RUN) && (w_illegal || w_conf_hit || w_wd_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_conf_cnt <= '0;
    else if (r_state == ST_RUN && !w_fault_now) r_conf_cnt <= w_conf_inc;
    else                                       r_conf_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_code      <= FC_NONE;
      r_init_cnt  <= '0;
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
      r_lamp      <= {4{LAMP_RED}};
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_init_cnt  <= w_init_nxt;
      r_blink     <= w_blink_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_lamp      <= w_lamp_nxt;
    end
  end

  // NOTE: every value driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_code_nxt      = r_code;
    w_init_nxt      = '0;
    w_blink_nxt     = 1'b1;
    w_blink_cnt_nxt = '0;
    w_lamp_nxt      = {4{LAMP_RED}};
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt + INIT_W'(1) == INIT_MAX) w_state_nxt = ST_RUN;
        else                                    w_init_nxt  = r_init_cnt + INIT_W'(1);
      end
      ST_RUN: begin
        if (w_fault_now) begin
          w_state_nxt = ST_FAULT;
          if (w_illegal)       w_code_nxt = FC_ILLEGAL;
          else if (w_conf_hit) w_code_nxt = FC_CONFLICT;
          else                 w_code_nxt = FC_WATCHDOG;
        end else begin
          for (int i = 0; i < 4; i++) w_lamp_nxt[i] = decode_lamp(r_in_q[i]);
        end
      end
      ST_FAULT: begin
        if (bus.clr_fault) begin
          w_state_nxt = ST_INIT;
          w_code_nxt  = FC_NONE;
        end else begin
          if (r_blink_cnt == BLINK_LAST) begin
            w_blink_nxt = ~r_blink;
          end else begin
            w_blink_nxt     = r_blink;
            w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
          end
          for (int i = 0; i < 4; i++) w_lamp_nxt[i] = {w_blink_nxt, 2'b00};
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign bus.n_lamp     = r_lamp[0];
  assign bus.s_lamp     = r_lamp[1];
  assign bus.e_lamp     = r_lamp[2];
  assign bus.w_lamp     = r_lamp[3];
  assign bus.fault      = (r_state == ST_FAULT);
  assign bus.fault_code = r_code;

endmodule
